// File: rtl/vde_scroll_map_emitter.sv
`default_nettype none
// ============================================================================
// Module   : vde_scroll_map_emitter
// Purpose  : Walks a wrap-scrolled viewport of the tile map in raster order and
//            streams {cell, row-in-tile, last, eof} to the sprite renderer.
// Revision : 1.0
// ============================================================================
module vde_scroll_map_emitter #(
  parameter int MAP_W      = 80,
  parameter int MAP_H      = 60,
  parameter int VIEW_W     = 80,
  parameter int VIEW_H     = 60,
  parameter int TILE_H     = 8,
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 13
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       frame_start_i,
  input  logic [$clog2(MAP_W)-1:0]   scroll_tx_i,
  input  logic [$clog2(MAP_H)-1:0]   scroll_ty_i,
  input  logic [$clog2(TILE_H)-1:0]  scroll_fy_i,
  output logic                       busy_o,
  output logic                       frame_done_o,
  output logic                       sprite_valid_o,
  input  logic                       sprite_ready_i,
  output logic [DATA_W-1:0]          sprite_data_o,
  output logic [$clog2(TILE_H)-1:0]  sprite_row_o,
  output logic                       sprite_last_o,
  output logic                       sprite_eof_o,
  output logic [ADDR_W-1:0]          map_mem_addr_o,
  output logic                       map_mem_fetch_o,
  input  logic [DATA_W-1:0]          map_mem_data_i,
  input  logic                       map_mem_done_i
);

  localparam int RW   = $clog2(TILE_H);
  localparam int TXW  = $clog2(MAP_W);
  localparam int TYW  = $clog2(MAP_H);
  localparam int CW   = (VIEW_W > 1) ? $clog2(VIEW_W) : 1;
  localparam int PW   = (VIEW_H * TILE_H > 1) ? $clog2(VIEW_H * TILE_H) : 1;
  localparam int PTRW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0]     COL_LAST  = CW'(VIEW_W - 1);
  localparam logic [PW-1:0]     PROW_LAST = PW'(VIEW_H * TILE_H - 1);
  localparam logic [TXW-1:0]    X_LAST    = TXW'(MAP_W - 1);
  localparam logic [TYW-1:0]    Y_LAST    = TYW'(MAP_H - 1);
  localparam logic [RW-1:0]     CY_LAST   = RW'(TILE_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(MAP_W);
  localparam logic [PTRW:0]     DEPTH_C   = (PTRW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nx;
  logic   frame_done_nx;
  logic   drop;

  // walk position of the next cell to fetch
  logic [TXW-1:0]    tx_l;
  logic [TXW-1:0]    x;
  logic [TYW-1:0]    y;
  logic [RW-1:0]     cy;
  logic [ADDR_W-1:0] row_base;
  logic [CW-1:0]     col;
  logic [PW-1:0]     prow;

  logic [TXW-1:0]    tx_eff;
  logic [TYW-1:0]    ty_eff;
  logic              elem_last;
  logic              elem_eof;
  logic              push;
  logic              pop;

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [RW-1:0]     fifo_row  [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];
  logic              fifo_eof  [FIFO_DEPTH];
  logic [PTRW-1:0]   wr_ptr;
  logic [PTRW-1:0]   rd_ptr;
  logic [PTRW:0]     count;

  // Start-row base addresses are elaboration constants, so seeding the walk
  // at an arbitrary ty needs only a table lookup rather than a multiply.
  logic [ADDR_W-1:0] rb_table [2**TYW];

  genvar gi;
  generate
    for (gi = 0; gi < 2**TYW; gi++) begin : g_rb
      assign rb_table[gi] = (gi < MAP_H) ? ADDR_W'(gi * MAP_W) : '0;
    end
  endgenerate

  assign tx_eff = ({1'b0, scroll_tx_i} < (TXW + 1)'(MAP_W)) ? scroll_tx_i : '0;
  assign ty_eff = ({1'b0, scroll_ty_i} < (TYW + 1)'(MAP_H)) ? scroll_ty_i : '0;

  assign elem_last = (col == COL_LAST);
  assign elem_eof  = elem_last && (prow == PROW_LAST);

  // The pending request already owns a slot, so holding the request never
  // violates the throttle: occupancy cannot grow until this request lands.
  assign map_mem_fetch_o = (state == FETCH) && !drop && (count < DEPTH_C);
  assign map_mem_addr_o  = row_base + ADDR_W'(x);
  assign push            = map_mem_fetch_o && map_mem_done_i;
  assign pop             = sprite_valid_o && sprite_ready_i;

  assign busy_o         = (state != IDLE);
  assign sprite_valid_o = (count != '0);
  assign sprite_data_o  = fifo_data[rd_ptr];
  assign sprite_row_o   = fifo_row[rd_ptr];
  assign sprite_last_o  = fifo_last[rd_ptr];
  assign sprite_eof_o   = fifo_eof[rd_ptr];

  always_comb begin
    state_nx      = state;
    frame_done_nx = 1'b0;
    if (frame_start_i) begin
      state_nx = FETCH;
    end else begin
      case (state)
        IDLE: ;
        FETCH: begin
          if (push && elem_eof) state_nx = DRAIN;
        end
        DRAIN: begin
          if (pop && sprite_eof_o) begin
            state_nx      = IDLE;
            frame_done_nx = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      frame_done_o <= 1'b0;
      drop         <= 1'b0;
    end else begin
      state        <= state_nx;
      frame_done_o <= frame_done_nx;
      drop         <= frame_start_i && (state != IDLE);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_l     <= '0;
      x        <= '0;
      y        <= '0;
      cy       <= '0;
      row_base <= '0;
      col      <= '0;
      prow     <= '0;
    end else if (frame_start_i) begin
      tx_l     <= tx_eff;
      x        <= tx_eff;
      y        <= ty_eff;
      cy       <= scroll_fy_i;
      row_base <= rb_table[ty_eff];
      col      <= '0;
      prow     <= '0;
    end else if (push) begin
      if (elem_last) begin
        col  <= '0;
        x    <= tx_l;
        prow <= prow + 1'b1;
        if (cy == CY_LAST) begin
          cy <= '0;
          if (y == Y_LAST) begin
            y        <= '0;
            row_base <= '0;
          end else begin
            y        <= y + 1'b1;
            row_base <= row_base + ROW_STEP;
          end
        end else begin
          cy <= cy + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
        x   <= (x == X_LAST) ? '0 : x + 1'b1;
      end
    end
  end

  // Entry storage is reset so the head, which drives the outputs directly,
  // reads as zero after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_row[i]  <= '0;
        fifo_last[i] <= 1'b0;
        fifo_eof[i]  <= 1'b0;
      end
    end else if (frame_start_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= map_mem_data_i;
        fifo_row[wr_ptr]  <= cy;
        fifo_last[wr_ptr] <= elem_last;
        fifo_eof[wr_ptr]  <= elem_eof;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vde_scroll_map_emitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vde_scroll_map_emitter
// Purpose  : Directed self-checking bench for vde_scroll_map_emitter.
// Revision : 1.0
// ============================================================================
module tb_vde_scroll_map_emitter;

  localparam int MAP_W = 4, MAP_H = 3, VIEW_W = 3, VIEW_H = 2, TILE_H = 2;
  localparam int DATA_W = 9, FIFO_DEPTH = 4, ADDR_W = 4;
  localparam int N = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              frame_start = 1'b0;
  logic [1:0]        tx = '0;
  logic [1:0]        ty = '0;
  logic              fy = 1'b0;
  logic              busy, frame_done, sv, seof, slast, srow;
  logic              sready = 1'b1;
  logic [DATA_W-1:0] sdata;
  logic [ADDR_W-1:0] maddr;
  logic              mfetch, mdone;
  logic [DATA_W-1:0] mdata;
  logic              force_done = 1'b0;
  int                lat = 0;
  int                wait_cnt = 0;

  int vecs = 0;
  int errs = 0;

  vde_scroll_map_emitter #(
    .MAP_W(MAP_W), .MAP_H(MAP_H), .VIEW_W(VIEW_W), .VIEW_H(VIEW_H),
    .TILE_H(TILE_H), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .frame_start_i(frame_start),
    .scroll_tx_i(tx), .scroll_ty_i(ty), .scroll_fy_i(fy),
    .busy_o(busy), .frame_done_o(frame_done),
    .sprite_valid_o(sv), .sprite_ready_i(sready), .sprite_data_o(sdata),
    .sprite_row_o(srow), .sprite_last_o(slast), .sprite_eof_o(seof),
    .map_mem_addr_o(maddr), .map_mem_fetch_o(mfetch),
    .map_mem_data_i(mdata), .map_mem_done_i(mdone)
  );

  always #5 clk = ~clk;

  // memory model: data = address, done after 'lat' waiting cycles
  assign mdata = DATA_W'(maddr);
  assign mdone = (mfetch && (wait_cnt >= lat)) || force_done;

  always @(posedge clk) begin
    if (!mfetch || mdone) wait_cnt <= 0;
    else                  wait_cnt <= wait_cnt + 1;
  end

  logic [11:0]       got[$];
  int                done_pulses = 0, pushes = 0, pops = 0, addr_moves = 0, fetch_cycles = 0;
  logic              held = 1'b0;
  logic [ADDR_W-1:0] held_addr = '0;

  always @(negedge clk) begin
    if (sv && sready) begin
      got.push_back({sdata, srow, slast, seof});
      pops++;
    end
    if (frame_done) done_pulses++;
    if (mfetch && mdone) pushes++;
    if (mfetch) fetch_cycles++;
    if (held && mfetch && (maddr !== held_addr)) addr_moves++;
    held      = mfetch && !mdone;
    held_addr = maddr;
  end

  int nd_data[N] = '{0, 1, 2, 0, 1, 2, 4, 5, 6, 4, 5, 6};
  int nd_row [N] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
  int wr_data[N] = '{11, 8, 9, 3, 0, 1, 3, 0, 1, 7, 4, 5};
  int wr_row [N] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};

  int gb = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // returns one cycle after the frame_start edge
  task automatic start(input logic [1:0] sx, input logic [1:0] sy, input logic sf);
    @(posedge clk);
    #1;
    tx = sx; ty = sy; fy = sf; frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    gb = got.size();
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    check("frame_done_seen", 32'(seen), 32'd1);
    check("idle_at_done", 32'(busy), 32'd0);
  endtask

  task automatic check_seq(input string tag, input int d[N], input int r[N]);
    int n;
    logic [11:0] e;
    n = got.size() - gb;
    check({tag, "_count"}, 32'(n), 32'(N));
    for (int i = 0; i < N && i < n; i++) begin
      e = {DATA_W'(d[i]), 1'(r[i]), (i % 3 == 2), (i == N - 1)};
      check($sformatf("%s_elem%0d", tag, i), 32'(got[gb + i]), 32'(e));
    end
  endtask

  initial begin
    int db, am, fc, mx, b;

    // reset values
    step(3);
    check("rst_busy", 32'(busy), 0);
    check("rst_fetch", 32'(mfetch), 0);
    check("rst_valid", 32'(sv), 0);
    check("rst_addr", 32'(maddr), 0);
    check("rst_data", 32'(sdata), 0);
    check("rst_done", 32'(frame_done), 0);
    rst = 1'b0;
    step(2);
    check("idle_no_fetch", 32'(mfetch), 0);

    // no scroll
    db = done_pulses;
    start(2'd0, 2'd0, 1'b0);
    check("ns_busy", 32'(busy), 1);
    check("ns_fetch", 32'(mfetch), 1);
    check("ns_addr0", 32'(maddr), 0);
    check("ns_valid_lat", 32'(sv), 0);
    step(1);
    check("ns_valid_first", 32'(sv), 1);
    check("ns_data_first", 32'(sdata), 0);
    wait_done(100);
    step(2);
    check_seq("noscroll", nd_data, nd_row);
    check("ns_done_pulses", 32'(done_pulses - db), 1);

    // wrap scroll
    db = done_pulses;
    start(2'd3, 2'd2, 1'b1);
    check("wr_addr0", 32'(maddr), 11);
    wait_done(100);
    step(2);
    check_seq("wrap", wr_data, wr_row);
    check("wr_done_pulses", 32'(done_pulses - db), 1);

    // backpressure
    db = done_pulses;
    start(2'd0, 2'd0, 1'b0);
    step(4);
    sready = 1'b0;
    mx = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      b = pushes - pops;
      if (b > mx) mx = b;
    end
    check("bp_max_buffered", 32'(mx), 32'(FIFO_DEPTH));
    check("bp_fetch_throttled", 32'(mfetch), 0);
    check("bp_valid_held", 32'(sv), 1);
    sready = 1'b1;
    wait_done(200);
    step(2);
    check_seq("backpressure", nd_data, nd_row);
    check("bp_done_pulses", 32'(done_pulses - db), 1);

    // slow memory
    lat = 5;
    db = done_pulses;
    am = addr_moves;
    start(2'd0, 2'd0, 1'b0);
    wait_done(400);
    step(2);
    check_seq("slow", nd_data, nd_row);
    check("slow_addr_stable", 32'(addr_moves - am), 0);
    check("slow_done_pulses", 32'(done_pulses - db), 1);

    // restart mid-row with a fetch outstanding
    db = done_pulses;
    start(2'd0, 2'd0, 1'b0);
    step(8);
    check("rs_fetch_outstanding", 32'(mfetch), 1);
    start(2'd3, 2'd2, 1'b1);
    force_done = 1'b1;
    check("rs_drop_fetch", 32'(mfetch), 0);
    check("rs_busy", 32'(busy), 1);
    step(1);
    force_done = 1'b0;
    check("rs_fetch_resumed", 32'(mfetch), 1);
    check("rs_addr", 32'(maddr), 11);
    wait_done(400);
    step(2);
    check_seq("restart", wr_data, wr_row);
    check("rs_done_pulses", 32'(done_pulses - db), 1);

    // reset mid-frame
    lat = 0;
    start(2'd0, 2'd0, 1'b0);
    step(5);
    rst = 1'b1;
    step(1);
    check("mr_busy", 32'(busy), 0);
    check("mr_fetch", 32'(mfetch), 0);
    check("mr_valid", 32'(sv), 0);
    check("mr_data", 32'(sdata), 0);
    check("mr_row", 32'(srow), 0);
    check("mr_last", 32'(slast), 0);
    check("mr_eof", 32'(seof), 0);
    check("mr_addr", 32'(maddr), 0);
    check("mr_done", 32'(frame_done), 0);
    rst = 1'b0;
    fc = fetch_cycles;
    step(10);
    check("mr_no_fetch", 32'(fetch_cycles - fc), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vde_scroll_map_emitter.md
# vde_scroll_map_emitter

Parametrised tile-map emitter for the video display engine. Walks a rectangular viewport of the tile map once per frame, in raster order, with wrap-around tile/fine scrolling. For each tile on each pixel row it fetches the map cell from map memory and streams it to the sprite renderer as a tile index plus row-within-tile. A prefetch FIFO decouples map-memory latency from renderer backpressure, and line/frame markers are added.

## Interface
- MAP_W, 80: map width in tiles
- MAP_H, 60: map height in tiles
- VIEW_W, 80: viewport width in tiles, ≤ MAP_W
- VIEW_H, 60: viewport height in tiles, ≤ MAP_H
- TILE_H, 8: pixel rows per tile, power of two ≥ 2
- DATA_W, 9: map cell / sprite index width
- FIFO_DEPTH, 4: prefetch entries, power of two ≥ 2
- ADDR_W, 13: map memory address width, 2^ADDR_W ≥ MAP_W*MAP_H
- Derived: RW = log2(TILE_H)

Ports (clock and reset first):
- clk_i  in  1  single clock
- rst_i  in  1  reset, synchronous, active-high
- frame_start_i  in  1  one-cycle pulse; latches scroll and (re)starts a frame
- scroll_tx_i  in  clog2(MAP_W)  first viewport column (tiles)
- scroll_ty_i  in  clog2(MAP_H)  first viewport row (tiles)
- scroll_fy_i  in  RW  fine vertical offset (pixel rows)
- busy_o  out  1  frame in progress
- frame_done_o  out  1  one-cycle pulse after the final element is accepted
- sprite_valid_o  out  1  output element valid
- sprite_ready_i  in  1  renderer accepts
- sprite_data_o  out  DATA_W  map cell
- sprite_row_o  out  RW  row within tile
- sprite_last_o  out  1  last element of a pixel row
- sprite_eof_o  out  1  last element of the frame
- map_mem_addr_o  out  ADDR_W  cell address = y*MAP_W + x
- map_mem_fetch_o  out  1  request, held until done
- map_mem_data_i  in  DATA_W  cell data
- map_mem_done_i  in  1  completion; counts only when map_mem_fetch_o=1 in the same cycle

## Operation
- States: IDLE, FETCH, DRAIN.
  - IDLE → FETCH on frame_start_i.
  - FETCH → DRAIN when the last address completes.
  - DRAIN → IDLE when the FIFO is empty and the final element has been accepted. frame_done_o pulses on that transition.
- Frame latch: tx, ty and fy are captured at frame_start_i. Out-of-range values (tx ≥ MAP_W, ty ≥ MAP_H) are replaced by 0.
- Walk: VIEW_H*TILE_H pixel rows, each with VIEW_W elements.
  - cy starts at fy. x starts at tx and increments modulo MAP_W.
  - At the end of each pixel row, x returns to tx and cy increments. When cy wraps from TILE_H-1 to 0, y increments modulo MAP_H.
- Address is computed incrementally, with no multiplier:
  - row_base = y*MAP_W is updated by +MAP_W, wrapping to 0 after row MAP_H-1.
  - addr = row_base + x.
- Each FIFO entry holds {data, cy, last, eof}, captured together with the fetch.
- Fetch throttle: a new request is issued only while (FIFO occupancy + outstanding) < FIFO_DEPTH. Outstanding is 0 or 1.
- Restart: frame_start_i in any state:
  - flushes the FIFO;
  - drops map_mem_fetch_o for one cycle, abandoning any outstanding request;
  - relatches scroll and restarts the walk.
  - A done arriving in the drop cycle is ignored. frame_done_o does not pulse for an aborted frame.
- rst_i wins over frame_start_i in the same cycle.

## Timing
- Reset values: busy_o=0, frame_done_o=0, sprite_valid_o=0, sprite_data_o=0, sprite_row_o=0, sprite_last_o=0, sprite_eof_o=0, map_mem_fetch_o=0, map_mem_addr_o=0. State is IDLE and the FIFO is empty.
- frame_start_i at cycle T → busy_o=1 and map_mem_fetch_o=1 at T+1, with the first address.
- Done at cycle D → entry written at D. sprite_valid_o=1 at D+1 if the FIFO was empty (one-cycle latency, registered output).
- On a done, map_mem_fetch_o stays high in D+1 with the next address if the throttle allows. Peak throughput is one element per cycle.
- Output holds stable while sprite_valid_o=1 and sprite_ready_i=0.
- An empty FIFO with an in-flight fetch produces no bubble beyond the one-cycle latency.
- Simultaneous FIFO write and read when full-minus-one or empty: legal; occupancy stays correct.

## Test plan
Common bench setup: MAP_W=4, MAP_H=3, VIEW_W=3, VIEW_H=2, TILE_H=2, memory returns data=addr with 1-cycle done, ready always 1.

- No scroll: tx=0, ty=0, fy=0.
  - data in order 0,1,2 | 0,1,2 | 4,5,6 | 4,5,6.
  - rows 0,1,0,1 per group.
  - last on every third element; eof only on the final 6.
  - frame_done_o pulses once.
- Wrap scroll: tx=3, ty=2, fy=1.
  - data in order 11,8,9 (row 1) | 3,0,1 (row 0) | 3,0,1 (row 1) | 7,4,5 (row 0).
- Backpressure: hold ready=0 for 20 cycles mid-frame.
  - At most FIFO_DEPTH entries are buffered, and fetch stays low once the throttle is reached.
  - After release, the full sequence completes with no loss or duplication.
- Slow memory: done 5 cycles after each request.
  - Same data sequence as the no-scroll case.
  - map_mem_addr_o stays stable while fetch is held.
- Restart: frame_start_i mid-row with a fetch outstanding.
  - Fetch is low for 1 cycle and a stale done in that cycle is ignored.
  - Output restarts at the first element of the new scroll.
  - No frame_done_o pulse for the aborted frame.
- Reset mid-frame: rst_i for 1 cycle.
  - All outputs return to their reset values next cycle.
  - With no frame_start_i, no fetch occurs.
